stream_fifo: RTL and testbench



---
 rtl/stream_pkg.sv | 7 +
 rtl/stream_fifo_ram.sv | 20 ++
 rtl/stream_fifo.sv | 93 +++++++++
 tb/tb_stream_fifo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// stream_pkg: shared defaults and idle-state encodings for the stream FIFO
package stream_pkg;
    localparam int DEF_IW          = 64;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_IDLE_CYCLES = 8;
    typedef enum logic [1:0] {IDLE_CLEAN, DIRTY, ARMED} idle_state_t;
endpackage

// File: rtl/stream_fifo_ram.sv
// stream_fifo_ram: DEPTH x IW storage, one synchronous write port, one asynchronous read port
module stream_fifo_ram #(
    parameter int IW    = 64,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);
    logic [IW-1:0] mem [DEPTH];
    // Contents are deliberately never reset; occupancy tracking makes stale words invisible
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: registered-state stream FIFO; define STREAM_FIFO_FLUSH_EN to add the idle flush pulse
module stream_fifo
    import stream_pkg::*;
#(
    parameter int IW          = DEF_IW,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IW-1:0]              idata,
    input  logic                       ivalid,
    output logic                       iready,
    output logic [IW-1:0]              odata,
    output logic                       ovalid,
    input  logic                       oready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       flush
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IDLE_CYCLES < 1 || IDLE_CYCLES > 255) begin : g_bad_params
        $error("stream_fifo: DEPTH must be a power of two >= 2 and IDLE_CYCLES within 1..255");
    end

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          ifire, ofire;

    assign iready = count != CW'(DEPTH);
    assign ovalid = count != '0;
    assign ifire  = ivalid && iready;
    assign ofire  = ovalid && oready;

    stream_fifo_ram #(.IW(IW), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ifire),
        .waddr (wr_ptr),
        .wdata (idata),
        .raddr (rd_ptr),
        .rdata (odata)
    );

    // Pointers wrap naturally at DEPTH; count moves only when exactly one side fires
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (ifire) wr_ptr <= wr_ptr + AW'(1);
            if (ofire) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(ifire) - CW'(ofire);
        end
    end

`ifdef STREAM_FIFO_FLUSH_EN
    idle_state_t state;
    logic [7:0]  idle_cnt;
    logic [7:0]  idle_nxt;
    assign idle_nxt = idle_cnt + 8'd1;
    // After a read, count empty write-free cycles and pulse flush once per quiet period
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE_CLEAN;
            idle_cnt <= '0;
            flush    <= 1'b0;
        end else begin
            flush <= 1'b0;
            if (ofire) begin
                state    <= DIRTY;
                idle_cnt <= '0;
            end else if (state != IDLE_CLEAN) begin
                if (count == '0 && !ifire) begin
                    if (idle_nxt == 8'(IDLE_CYCLES)) begin
                        flush    <= 1'b1;
                        state    <= IDLE_CLEAN;
                        idle_cnt <= '0;
                    end else begin
                        state    <= ARMED;
                        idle_cnt <= idle_nxt;
                    end
                end else begin
                    state    <= DIRTY;
                    idle_cnt <= '0;
                end
            end
        end
    end
`else
    assign flush = 1'b0;
`endif
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: randomized self-checking bench for stream_fifo against a queue model
module tb_stream_fifo;
    localparam int IW    = 64;
    localparam int DEPTH = 16;
    localparam int IDLE  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] idata = '0;
    logic          ivalid = 1'b0;
    logic          iready;
    logic [IW-1:0] odata;
    logic          ovalid;
    logic          oready = 1'b0;
    logic [4:0]    count;
    logic          flush;

    int errors = 0;
    int checks = 0;

    logic [IW-1:0] q[$];
    bit  dirty = 0;
    int  run = 0;
    bit  exp_flush = 0;
    int  total_wr = 0;
    int  total_rd = 0;

    stream_fifo #(.IW(IW), .DEPTH(DEPTH), .IDLE_CYCLES(IDLE)) dut (
        .clk    (clk),
        .rst    (rst),
        .idata  (idata),
        .ivalid (ivalid),
        .iready (iready),
        .odata  (odata),
        .ovalid (ovalid),
        .oready (oready),
        .count  (count),
        .flush  (flush)
    );

    always #5 clk = ~clk;

    task automatic step();
        bit w, r;
        w = ivalid && (q.size() != DEPTH);
        r = oready && (q.size() != 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
            dirty = 0;
            run = 0;
            exp_flush = 0;
        end else begin
            exp_flush = 0;
`ifdef STREAM_FIFO_FLUSH_EN
            if (r) begin
                dirty = 1;
                run = 0;
            end else if (dirty) begin
                if (q.size() == 0 && !w) begin
                    run++;
                    if (run == IDLE) begin
                        exp_flush = 1;
                        dirty = 0;
                        run = 0;
                    end
                end else run = 0;
            end
`endif
            if (r) begin
                void'(q.pop_front());
                total_rd++;
            end
            if (w) begin
                q.push_back(idata);
                total_wr++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got=%b exp=0", ovalid); end
        checks++; if (iready !== 1'b1) begin errors++; $display("FAIL reset_iready got=%b exp=1", iready); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
    endtask

    task automatic test_fill_drain();
        oready = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            ivalid = 1'b1;
            idata = IW'(i);
            step();
            checks++; if (count !== 5'(i)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", count, i); end
        end
        ivalid = 1'b0;
        checks++; if (iready !== 1'b0) begin errors++; $display("FAIL fill_iready got=%b exp=0", iready); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_full got=%0d exp=16", count); end
        oready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            checks++; if (ovalid !== 1'b1 || odata !== IW'(i)) begin errors++; $display("FAIL drain_data got=%0h v=%b exp=%0h", odata, ovalid, i); end
            step();
        end
        oready = 1'b0;
        checks++; if (ovalid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL drain_empty got v=%b c=%0d exp v=0 c=0", ovalid, count); end
    endtask

    task automatic test_latency();
        ivalid = 1'b1;
        idata = 64'hA5;
        step();
        ivalid = 1'b0;
        checks++; if (ovalid !== 1'b1 || odata !== 64'hA5 || count !== 5'd1) begin
            errors++; $display("FAIL latency got v=%b d=%0h c=%0d exp v=1 d=a5 c=1", ovalid, odata, count);
        end
        oready = 1'b1;
        step();
        oready = 1'b0;
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < DEPTH; i++) begin
            ivalid = 1'b1;
            idata = {$urandom, $urandom};
            step();
        end
        checks++; if (count !== 5'd16 || iready !== 1'b0) begin errors++; $display("FAIL fullpop_pre got c=%0d r=%b exp c=16 r=0", count, iready); end
        oready = 1'b1;
        idata = 64'hDEAD_BEEF;
        checks++; if (odata !== q[0]) begin errors++; $display("FAIL fullpop_head got=%0h exp=%0h", odata, q[0]); end
        step();
        checks++; if (count !== 5'd15 || iready !== 1'b1) begin errors++; $display("FAIL fullpop_pop got c=%0d r=%b exp c=15 r=1", count, iready); end
        oready = 1'b0;
        step();
        ivalid = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fullpop_accept got=%0d exp=16", count); end
        oready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (odata !== q[0]) begin errors++; $display("FAIL fullpop_drain got=%0h exp=%0h", odata, q[0]); end
            step();
        end
        oready = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL fullpop_end got=%0d exp=0", count); end
    endtask

    task automatic test_wrap();
        int wr0, rd0, cyc;
        wr0 = total_wr;
        rd0 = total_rd;
        cyc = 0;
        while ((total_wr - wr0 < 40 || q.size() != 0) && cyc < 2000) begin
            ivalid = (total_wr - wr0 < 40) ? 1'($urandom % 2) : 1'b0;
            oready = 1'($urandom % 2);
            idata = {$urandom, $urandom};
            checks++; if (ovalid !== (q.size() != 0) || count !== 5'(q.size())) begin
                errors++; $display("FAIL wrap_state got v=%b c=%0d exp c=%0d", ovalid, count, q.size());
            end
            if (q.size() != 0) begin
                checks++; if (odata !== q[0]) begin errors++; $display("FAIL wrap_data got=%0h exp=%0h", odata, q[0]); end
            end
            step();
            cyc++;
        end
        ivalid = 1'b0;
        oready = 1'b0;
        checks++; if (cyc >= 2000 || total_rd - rd0 != 40) begin errors++; $display("FAIL wrap_budget got reads=%0d exp=40", total_rd - rd0); end
        checks++; if (total_wr < 2 * DEPTH + 1) begin errors++; $display("FAIL wrap_laps got writes=%0d exp>=%0d", total_wr, 2 * DEPTH + 1); end
    endtask

    task automatic test_flush();
        int pulses;
        pulses = 0;
        ivalid = 1'b1;
        idata = 64'h11;
        step();
        ivalid = 1'b0;
        oready = 1'b1;
        step();
        for (int i = 0; i < 30; i++) begin
            checks++; if (flush !== exp_flush) begin errors++; $display("FAIL flush_quiet cyc=%0d got=%b exp=%b", i, flush, exp_flush); end
            if (flush) pulses++;
            step();
        end
`ifdef STREAM_FIFO_FLUSH_EN
        checks++; if (pulses != 1) begin errors++; $display("FAIL flush_pulses got=%0d exp=1", pulses); end
`else
        checks++; if (pulses != 0) begin errors++; $display("FAIL flush_pulses got=%0d exp=0", pulses); end
`endif
        ivalid = 1'b1;
        idata = 64'h22;
        step();
        ivalid = 1'b0;
        step();
        for (int i = 0; i < 30; i++) begin
            ivalid = (i == 5);
            idata = 64'h33;
            checks++; if (flush !== exp_flush) begin errors++; $display("FAIL flush_restart cyc=%0d got=%b exp=%b", i, flush, exp_flush); end
            step();
        end
        ivalid = 1'b0;
        oready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            ivalid = 1'b1;
            idata = IW'(100 + i);
            step();
        end
        checks++; if (count !== 5'd7) begin errors++; $display("FAIL mid_pre got=%0d exp=7", count); end
        rst = 1'b1;
        idata = 64'h77;
        step();
        rst = 1'b0;
        ivalid = 1'b0;
        checks++; if (count !== 5'd0 || ovalid !== 1'b0 || iready !== 1'b1 || flush !== 1'b0) begin
            errors++; $display("FAIL mid_reset got c=%0d v=%b r=%b f=%b exp c=0 v=0 r=1 f=0", count, ovalid, iready, flush);
        end
        ivalid = 1'b1;
        idata = 64'h3C;
        step();
        ivalid = 1'b0;
        checks++; if (ovalid !== 1'b1 || odata !== 64'h3C || count !== 5'd1) begin
            errors++; $display("FAIL mid_first got v=%b d=%0h c=%0d exp v=1 d=3c c=1", ovalid, odata, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_latency();
        test_full_pop();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
